// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: request/response handshake and byte-memory bus of the data memory controller
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [12:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: serialises 64-bit LDUR/STUR accesses onto an 8-bit synchronous byte memory
module dmem_access_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  output logic               busy,
  dmem_access_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_LAST, DONE} state_t;
  state_t      state, nxt;
  logic [2:0]  cnt;
  logic [2:0]  prv;
  logic        up;
  logic        err;
  logic        accept;
  logic [12:0] base;
  logic [63:0] wdata;
  logic [63:0] rdata;
  assign prv           = cnt - 3'd1;
  // up keeps req_ready low until the first edge after reset release
  assign bus.req_ready = (state == IDLE) && up;
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = state != IDLE;
  assign bus.mem_en    = (state == WR) || (state == RD);
  assign bus.mem_we    = state == WR;
  assign bus.mem_addr  = bus.mem_en ? base + {10'd0, cnt} : 13'd0;
  assign bus.mem_wdata = bus.mem_we ? wdata[{cnt, 3'b000} +: 8] : 8'd0;
  assign bus.rsp_valid = state == DONE;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (|bus.req_addr[2:0]) ? DONE : bus.req_write ? WR : RD;
      WR:      if (cnt == 3'd7) nxt = DONE;
      RD:      if (cnt == 3'd7) nxt = RD_LAST;
      RD_LAST: nxt = DONE;
      DONE:    if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
      up    <= 1'b0;
      err   <= 1'b0;
      base  <= 13'd0;
      wdata <= 64'd0;
      rdata <= 64'd0;
    end else begin
      state <= nxt;
      up    <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          base  <= bus.req_addr;
          wdata <= bus.req_wdata;
          rdata <= 64'd0;
          err   <= |bus.req_addr[2:0];
          cnt   <= 3'd0;
        end
        WR: cnt <= cnt + 3'd1;
        // read data trails its issue by one cycle, so byte cnt-1 arrives now
        RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rdata[{prv, 3'b000} +: 8] <= bus.mem_rdata;
        end
        RD_LAST: rdata[63:56] <= bus.mem_rdata;
        default: ;
      endcase
    end
  end
endmodule
